// File: rtl/sram_word_port.sv
// sram_word_port: splits one 32-bit word read/write into two sequential
// 16-bit SRAM half-word accesses (low half first, then high half), each
// held for WAIT_CYCLES+1 clocks, and pulses done for one cycle at the end.
module sram_word_port #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        done,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must be able to hold WAIT_CYCLES; keep at least one bit so the
    // WAIT_CYCLES=0 build still elaborates cleanly.
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          is_write_reg;
    logic [15:0]   word_idx_reg;
    logic [31:0]   wdata_reg;

    logic [17:0]   offset;
    logic          half_last;
    logic          accept;
    logic          drive_dq;
    logic [15:0]   dq_out;
    logic          unused_ok;

    // Offset wraps modulo 2^18; addresses below the base simply alias high.
    assign offset    = address[17:0] - BASE_ADDR[17:0];
    assign half_last = (cnt_reg == CW'(WAIT_CYCLES));
    assign accept    = (state_reg == IDLE) && (wr_en || rd_en);

    // Upper address bits and the byte offset inside the word are don't-care.
    assign unused_ok = &{1'b0, address[31:18], offset[1:0]};

    // State and wait counter registers, cleared by the active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: each half stays until the counter reaches WAIT_CYCLES.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (wr_en || rd_en) begin
                    state_next = LO;
                    cnt_next   = '0;
                end
            end
            LO: begin
                if (half_last) begin
                    state_next = HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            HI: begin
                if (half_last) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch: op, word index and write data are frozen at acceptance
    // so later input changes cannot disturb the transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            is_write_reg <= 1'b0;
            word_idx_reg <= '0;
            wdata_reg    <= '0;
        end else if (accept) begin
            is_write_reg <= wr_en;
            word_idx_reg <= offset[17:2];
            wdata_reg    <= write_data;
        end
    end

    // Read capture: each half is sampled on the last edge of its access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            read_data <= '0;
        end else if (!is_write_reg && half_last) begin
            if (state_reg == LO) begin
                read_data[15:0] <= SRAM_DQ;
            end else if (state_reg == HI) begin
                read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    // SRAM pin decode from state: address/WE_N/data only active in LO and HI.
    always_comb begin
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        drive_dq  = 1'b0;
        dq_out    = '0;
        done      = 1'b0;
        case (state_reg)
            LO: begin
                SRAM_ADDR = {1'b0, word_idx_reg, 1'b0};
                SRAM_WE_N = ~is_write_reg;
                drive_dq  = is_write_reg;
                dq_out    = wdata_reg[15:0];
            end
            HI: begin
                SRAM_ADDR = {1'b0, word_idx_reg, 1'b1};
                SRAM_WE_N = ~is_write_reg;
                drive_dq  = is_write_reg;
                dq_out    = wdata_reg[31:16];
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    assign SRAM_DQ = drive_dq ? dq_out : 16'hzzzz;

endmodule
